// File: rtl/dsp_dot_ctrl.sv
// dsp_dot_ctrl: operand sequencer for a DSP48A1 slice computing length-LEN
// dot products. Operand pairs arrive on a valid/ready stream and go straight
// to the slice A/B inputs. OPMODE is sequenced as FIRST (multiply), ACC
// (multiply-accumulate) or HOLD (bubble). After the last pair the block waits
// for the slice pipeline, then captures slice P into a result register that is
// offered on a valid/ready stream.
//
// Ports:
//   CLK, RSTN             clock (rising edge), async active-low reset
//   in_valid/in_ready     operand pair handshake
//   in_a, in_b            18-bit operands
//   DSP_A, DSP_B          combinational copies of in_a/in_b to the slice
//   DSP_OPMODE            slice OPMODE, last stage of the internal OPMODE pipe
//   DSP_P                 48-bit slice P output
//   out_valid/out_ready   result handshake
//   out_data              captured dot-product result
//   busy                  group in progress or result pending
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting pairs, count = pairs taken so far in this group
// DRAIN | waiting for the slice pipeline to land the final sum in P
// DONE  | result held on out_data until out_ready
module dsp_dot_ctrl #(
  parameter int LEN     = 4,
  parameter int P_LAT   = 3,
  parameter int OPM_DLY = 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  input  logic [47:0] DSP_P,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic        busy
);

  localparam logic [7:0] OPM_FIRST  = 8'h01;
  localparam logic [7:0] OPM_ACC    = 8'h09;
  localparam logic [7:0] OPM_HOLD   = 8'h08;
  localparam logic [7:0] LEN_M1     = 8'(LEN - 1);
  localparam logic [7:0] DRAIN_INIT = 8'(P_LAT - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [7:0]  drain_cnt, drain_nxt;
  logic [7:0]  opm_src;
  logic [7:0]  opm_pipe [OPM_DLY];
  logic        accept;
  logic        capture;
  logic        done_ack;

  assign DSP_A      = in_a;
  assign DSP_B      = in_b;
  assign DSP_OPMODE = opm_pipe[OPM_DLY-1];

  // Decoded from registered state only; no path from in_valid/out_ready.
  assign in_ready = (state == ACCUM);
  assign busy     = (state != ACCUM) || (count != 8'd0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    drain_nxt = drain_cnt;
    opm_src   = OPM_HOLD;
    capture   = 1'b0;
    done_ack  = 1'b0;
    case (state)
      ACCUM: begin
        if (accept) begin
          // Z=0 on the first pair of every group, so stale P never leaks in.
          opm_src = (count == 8'd0) ? OPM_FIRST : OPM_ACC;
          if (count == LEN_M1) begin
            count_nxt = 8'd0;
            drain_nxt = DRAIN_INIT;
            state_nxt = DRAIN;
          end else begin
            count_nxt = count + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 8'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_cnt - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          done_ack  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ACCUM;
      count     <= 8'd0;
      drain_cnt <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 48'd0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      drain_cnt <= drain_nxt;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= DSP_P;
      end else if (done_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

  // OPMODE delay pipe; its depth matches the slice's OPMODE register so the
  // code meets its product at the P register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < OPM_DLY; i++) opm_pipe[i] <= OPM_HOLD;
    end else begin
      opm_pipe[0] <= opm_src;
      for (int i = 1; i < OPM_DLY; i++) opm_pipe[i] <= opm_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_dsp_dot_ctrl.sv
module tb_dsp_dot_ctrl;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [17:0] in_a, in_b, dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        out_valid, out_ready;
  logic [47:0] out_data;
  logic        busy;

  logic        v1_in_valid, v1_in_ready;
  logic [17:0] v1_in_a, v1_in_b, v1_dsp_a, v1_dsp_b;
  logic [7:0]  v1_dsp_opmode;
  logic [47:0] v1_dsp_p;
  logic        v1_out_valid, v1_out_ready;
  logic [47:0] v1_out_data;
  logic        v1_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dsp_dot_ctrl #(.LEN(4), .P_LAT(3), .OPM_DLY(1)) u_dut (
    .CLK(clk), .RSTN(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_OPMODE(dsp_opmode), .DSP_P(dsp_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  dsp_dot_ctrl #(.LEN(1), .P_LAT(3), .OPM_DLY(1)) u_dut1 (
    .CLK(clk), .RSTN(rst_n),
    .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_a(v1_in_a), .in_b(v1_in_b),
    .DSP_A(v1_dsp_a), .DSP_B(v1_dsp_b), .DSP_OPMODE(v1_dsp_opmode), .DSP_P(v1_dsp_p),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_data(v1_out_data),
    .busy(v1_busy)
  );

  // Behavioural DSP48A1 slice: A1/B1 reg, M reg, OPMODE reg, P reg.
  function automatic logic [47:0] slice_p(input logic [7:0] opm, input logic [47:0] m,
                                          input logic [47:0] p);
    logic [47:0] x, z;
    x = (opm[1:0] == 2'b01) ? m : 48'd0;
    z = (opm[3:2] == 2'b10) ? p : 48'd0;
    return z + x;
  endfunction

  logic [17:0] s_a1, s_b1, t_a1, t_b1;
  logic [47:0] s_m, t_m;
  logic [7:0]  s_opm, t_opm;
  wire signed [35:0] s_prod = $signed(s_a1) * $signed(s_b1);
  wire signed [35:0] t_prod = $signed(t_a1) * $signed(t_b1);

  always @(posedge clk) begin
    if (!rst_n) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= OPM_HOLD; dsp_p <= '0;
      t_a1 <= '0; t_b1 <= '0; t_m <= '0; t_opm <= OPM_HOLD; v1_dsp_p <= '0;
    end else begin
      s_a1 <= dsp_a; s_b1 <= dsp_b; s_m <= {{12{s_prod[35]}}, s_prod};
      s_opm <= dsp_opmode; dsp_p <= slice_p(s_opm, s_m, dsp_p);
      t_a1 <= v1_dsp_a; t_b1 <= v1_dsp_b; t_m <= {{12{t_prod[35]}}, t_prod};
      t_opm <= v1_dsp_opmode; v1_dsp_p <= slice_p(t_opm, t_m, v1_dsp_p);
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [7:0] code);
    chk("in_ready_before_send", in_ready, 1'b1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    chk("opmode_after_accept", dsp_opmode, code);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("opmode_bubble", dsp_opmode, OPM_HOLD);
    end
  endtask

  // Waits for out_valid after the last accept, checks latency and result.
  task automatic collect(input int hold);
    int lat;
    logic [47:0] e;
    chk("busy_drain", busy, 1'b1);
    chk("in_ready_drain", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("result_latency", lat, 3);
    e = (sb.size() > 0) ? sb.pop_front() : 48'hDEAD_DEAD_DEAD;
    chk("out_valid", out_valid, 1'b1);
    chk("result", out_data, e);
    chk("opmode_done", dsp_opmode, OPM_HOLD);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_valid", out_valid, 1'b1);
      chk("held_data", out_data, e);
      chk("held_in_ready", in_ready, 1'b0);
    end
  endtask

  typedef struct {
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    int               gap;
    int               hold;
    logic [47:0]      exp;
  } vec_t;

  task automatic run_group(input vec_t v);
    sb.push_back(v.exp);
    out_ready = (v.hold == 0);
    for (int i = 0; i < 4; i++) begin
      send(v.a[i], v.b[i], (i == 0) ? OPM_FIRST : OPM_ACC);
      if (i == 1) idle(v.gap);
    end
    collect(v.hold);
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_after_ack", out_valid, 1'b0);
    chk("in_ready_after_ack", in_ready, 1'b1);
  endtask

  vec_t vecs[6];
  vec_t fresh;

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_in_a = '0; v1_in_b = '0; v1_out_ready = 1'b1;

    vecs[0] = '{a: {18'd7, 18'd5, 18'd3, 18'd1}, b: {18'd8, 18'd6, 18'd4, 18'd2},
                gap: 0, hold: 0, exp: 48'd100};
    vecs[1] = '{a: {18'd7, 18'd5, 18'd3, 18'd1}, b: {18'd8, 18'd6, 18'd4, 18'd2},
                gap: 2, hold: 0, exp: 48'd100};
    vecs[2] = '{a: {18'd7, 18'd5, 18'd3, 18'd1}, b: {18'd8, 18'd6, 18'd4, 18'd2},
                gap: 0, hold: 6, exp: 48'd100};
    vecs[3] = '{a: {4{18'd10}}, b: {4{18'd10}}, gap: 0, hold: 0, exp: 48'd400};
    vecs[4] = '{a: {18'd0, 18'h3FFFF, 18'd2, 18'h3FFFD}, b: {18'd7, 18'h3FFFF, 18'd2, 18'd5},
                gap: 1, hold: 2, exp: 48'hFFFF_FFFF_FFF6};
    vecs[5] = '{a: {4{18'h20000}}, b: {4{18'h20000}}, gap: 0, hold: 0,
                exp: 48'h10_0000_0000};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 48'd0);
    chk("rst_opmode", dsp_opmode, OPM_HOLD);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) run_group(vecs[k]);

    // LEN=1 instance: single pair goes straight to DRAIN.
    sb.push_back(48'd17179607041);
    v1_in_valid = 1'b1; v1_in_a = 18'd131071; v1_in_b = 18'd131071;
    @(negedge clk);
    v1_in_valid = 1'b0;
    chk("len1_opmode", v1_dsp_opmode, OPM_FIRST);
    chk("len1_in_ready", v1_in_ready, 1'b0);
    lat = 0;
    while (!v1_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("len1_latency", lat, 3);
    chk("len1_result", v1_out_data, sb.pop_front());
    @(negedge clk);
    chk("len1_ack", v1_out_valid, 1'b0);

    // Contention: pair offered in DONE together with out_ready.
    sb.push_back(48'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(18'd1, 18'd1, (i == 0) ? OPM_FIRST : OPM_ACC);
    collect(1);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 18'd2; in_b = 18'd3;
    @(negedge clk);
    chk("contend_out_valid", out_valid, 1'b0);
    chk("contend_not_taken", dsp_opmode, OPM_HOLD);
    chk("contend_busy", busy, 1'b0);
    sb.push_back(48'd9);
    send(18'd2, 18'd3, OPM_FIRST);
    for (int i = 0; i < 3; i++) send(18'd1, 18'd1, OPM_ACC);
    collect(0);
    @(negedge clk);

    // Reset one edge after the 4th accept of a group.
    for (int i = 0; i < 4; i++)
      send(vecs[0].a[i], vecs[0].b[i], (i == 0) ? OPM_FIRST : OPM_ACC);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 48'd0);
    chk("midrst_opmode", dsp_opmode, OPM_HOLD);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fresh = '{a: {4{18'd2}}, b: {4{18'd3}}, gap: 0, hold: 0, exp: 48'd24};
    run_group(fresh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
